// File: rtl/cam_sequencer.sv
// Command front-end for the cam array: expands SEARCH / SELECT_FIRST / WRITE / READ into timed
// strobe sequences and returns the captured tags and read data over a valid/ready channel.
module cam_sequencer #(
    parameter int unsigned num_bits      = 2,
    parameter int unsigned num_cells     = 10,
    parameter int unsigned pulse_cycles  = 10,
    parameter int unsigned settle_cycles = 100
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [1:0]                     cmd_op,
    input  logic [num_bits-1:0]            cmd_data,
    input  logic [num_bits-1:0]            cmd_mask,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [num_cells-1:0]           rsp_tags,
    output logic [num_bits-1:0]            rsp_data,
    output logic                           rsp_any,
    output logic [$clog2(num_cells+1)-1:0] rsp_count,
    output logic [num_bits-1:0]            cam_comparand,
    output logic [num_bits-1:0]            cam_mask,
    output logic                           cam_set,
    output logic                           cam_perform_search,
    output logic                           cam_select_first,
    output logic [2*num_bits-1:0]          cam_write_lines,
    input  logic [num_cells-1:0]           cam_tag_wires,
    input  logic [num_bits-1:0]            cam_read_lines
);

    localparam int unsigned CountW   = $clog2(num_cells + 1);
    localparam int unsigned MaxPhase = (pulse_cycles > settle_cycles) ? pulse_cycles
                                                                      : settle_cycles;
    localparam int unsigned PhaseW   = $clog2(MaxPhase + 1);

    localparam logic [PhaseW-1:0] PulseLoad  = PhaseW'(pulse_cycles);
    localparam logic [PhaseW-1:0] SettleLoad = PhaseW'(settle_cycles);
    localparam logic [PhaseW-1:0] PhaseOne   = PhaseW'(1);

    localparam logic [1:0] OpSearch   = 2'b00;
    localparam logic [1:0] OpSelFirst = 2'b01;
    localparam logic [1:0] OpWrite    = 2'b10;

    typedef enum logic [3:0] {
        StIdle,
        StSet,
        StSetGap,
        StSrch,
        StSrchGap,
        StSel,
        StSelGap,
        StWr,
        StWrSettle,
        StRdWait,
        StResp
    } state_t;

    state_t            state;
    logic [PhaseW-1:0] phase_cnt;
    logic              phase_done;
    logic              capture;

    // Each masked bit becomes a one-hot pair: bit 2i drives a 1, bit 2i+1 drives a 0.
    function automatic logic [2*num_bits-1:0] encode_lines(input logic [num_bits-1:0] d,
                                                           input logic [num_bits-1:0] m);
        logic [2*num_bits-1:0] wl;
        wl = '0;
        for (int i = 0; i < num_bits; i++) begin
            wl[2*i]   = d[i] & m[i];
            wl[2*i+1] = ~d[i] & m[i];
        end
        return wl;
    endfunction

    assign phase_done = (phase_cnt == PhaseOne);
    assign capture    = phase_done && ((state == StSrchGap) || (state == StSelGap) ||
                                       (state == StWrSettle) || (state == StRdWait));
    assign cmd_ready  = (state == StIdle) && !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state              <= StIdle;
            phase_cnt          <= '0;
            cam_comparand      <= '0;
            cam_mask           <= '0;
            cam_set            <= 1'b0;
            cam_perform_search <= 1'b0;
            cam_select_first   <= 1'b0;
            cam_write_lines    <= '0;
            rsp_valid          <= 1'b0;
            rsp_tags           <= '0;
            rsp_data           <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (cmd_valid) begin
                        cam_comparand <= cmd_data;
                        cam_mask      <= cmd_mask;
                        phase_cnt     <= PulseLoad;
                        case (cmd_op)
                            OpSearch: begin
                                state   <= StSet;
                                cam_set <= 1'b1;
                            end
                            OpSelFirst: begin
                                state            <= StSel;
                                cam_select_first <= 1'b1;
                            end
                            OpWrite: begin
                                state           <= StWr;
                                cam_write_lines <= encode_lines(cmd_data, cmd_mask);
                            end
                            default: state <= StRdWait;
                        endcase
                    end
                end
                StSet: begin
                    if (phase_done) begin
                        state     <= StSetGap;
                        cam_set   <= 1'b0;
                        phase_cnt <= PulseLoad;
                    end else begin
                        phase_cnt <= phase_cnt - PhaseOne;
                    end
                end
                StSetGap: begin
                    if (phase_done) begin
                        state              <= StSrch;
                        cam_perform_search <= 1'b1;
                        phase_cnt          <= PulseLoad;
                    end else begin
                        phase_cnt <= phase_cnt - PhaseOne;
                    end
                end
                StSrch: begin
                    if (phase_done) begin
                        state              <= StSrchGap;
                        cam_perform_search <= 1'b0;
                        phase_cnt          <= PulseLoad;
                    end else begin
                        phase_cnt <= phase_cnt - PhaseOne;
                    end
                end
                StSel: begin
                    if (phase_done) begin
                        state            <= StSelGap;
                        cam_select_first <= 1'b0;
                        phase_cnt        <= PulseLoad;
                    end else begin
                        phase_cnt <= phase_cnt - PhaseOne;
                    end
                end
                StWr: begin
                    if (phase_done) begin
                        state           <= StWrSettle;
                        cam_write_lines <= '0;
                        phase_cnt       <= SettleLoad;
                    end else begin
                        phase_cnt <= phase_cnt - PhaseOne;
                    end
                end
                StSrchGap, StSelGap, StWrSettle, StRdWait: begin
                    if (!phase_done) begin
                        phase_cnt <= phase_cnt - PhaseOne;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase

            // Terminal quiet phase of every path samples the CAM and enters RESP.
            if (capture) begin
                state     <= StResp;
                rsp_valid <= 1'b1;
                rsp_tags  <= cam_tag_wires;
                rsp_data  <= (state == StRdWait) ? cam_read_lines : '0;
            end
        end
    end

    assign rsp_any = |rsp_tags;

    always_comb begin
        rsp_count = '0;
        for (int i = 0; i < num_cells; i++) begin
            rsp_count = rsp_count + CountW'(rsp_tags[i]);
        end
    end

endmodule

// File: tb/tb_cam_sequencer.sv
// Randomised scoreboard bench for cam_sequencer: a driver issues commands and plays a stub CAM,
// a negedge monitor checks strobes, handshakes and responses against a cycle-level reference.
module tb_cam_sequencer;

    localparam int P  = 10;
    localparam int S  = 100;
    localparam int NB = 2;
    localparam int NC = 10;
    localparam int CW = $clog2(NC + 1);

    localparam logic [1:0] OpSearch   = 2'b00;
    localparam logic [1:0] OpSelFirst = 2'b01;
    localparam logic [1:0] OpWrite    = 2'b10;
    localparam logic [1:0] OpRead     = 2'b11;

    typedef struct {
        logic [1:0]    op;
        logic [NB-1:0] data;
        logic [NB-1:0] mask;
        logic [NC-1:0] tags;
        logic [NB-1:0] rdata;
        int            lat;
        int            acc_edge;
    } cmd_t;

    logic            CLK;
    logic            RST;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [NB-1:0]   cmd_data;
    logic [NB-1:0]   cmd_mask;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [NC-1:0]   rsp_tags;
    logic [NB-1:0]   rsp_data;
    logic            rsp_any;
    logic [CW-1:0]   rsp_count;
    logic [NB-1:0]   cam_comparand;
    logic [NB-1:0]   cam_mask;
    logic            cam_set;
    logic            cam_perform_search;
    logic            cam_select_first;
    logic [2*NB-1:0] cam_write_lines;
    logic [NC-1:0]   cam_tag_wires;
    logic [NB-1:0]   cam_read_lines;

    cam_sequencer #(
        .num_bits     (NB),
        .num_cells    (NC),
        .pulse_cycles (P),
        .settle_cycles(S)
    ) dut (
        .CLK               (CLK),
        .RST               (RST),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_op            (cmd_op),
        .cmd_data          (cmd_data),
        .cmd_mask          (cmd_mask),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_tags          (rsp_tags),
        .rsp_data          (rsp_data),
        .rsp_any           (rsp_any),
        .rsp_count         (rsp_count),
        .cam_comparand     (cam_comparand),
        .cam_mask          (cam_mask),
        .cam_set           (cam_set),
        .cam_perform_search(cam_perform_search),
        .cam_select_first  (cam_select_first),
        .cam_write_lines   (cam_write_lines),
        .cam_tag_wires     (cam_tag_wires),
        .cam_read_lines    (cam_read_lines)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int   tests = 0;
    int   fails = 0;
    int   edge_n = 0;
    cmd_t acc_q[$];

    // Driver-side view of the in-flight command, used only to play the CAM.
    bit            drv_active = 0;
    int            drv_acc = 0;
    int            drv_cap = 0;
    logic [NC-1:0] drv_tags = '0;
    logic [NB-1:0] drv_rd = '0;
    bit            rand_ready = 0;

    function automatic int latency(input logic [1:0] op);
        case (op)
            OpSearch:   return 4 * P + 1;
            OpSelFirst: return 2 * P + 1;
            OpWrite:    return P + S + 1;
            default:    return P + 1;
        endcase
    endfunction

    function automatic logic [2*NB-1:0] lines_for(input logic [NB-1:0] d, input logic [NB-1:0] m);
        logic [2*NB-1:0] r;
        r = '0;
        for (int i = 0; i < NB; i++) begin
            if (m[i]) r[2*i +: 2] = d[i] ? 2'b01 : 2'b10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // The stub CAM shows the expected answer only in the cycle the DUT must sample it.
    task automatic drive_cam();
        if (drv_active && (edge_n - drv_acc + 1) == drv_cap) begin
            cam_tag_wires  = drv_tags;
            cam_read_lines = drv_rd;
        end else begin
            cam_tag_wires  = NC'($urandom);
            cam_read_lines = NB'($urandom);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        edge_n++;
        drive_cam();
        if (rand_ready) rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!cmd_ready && n < 600) begin
            step();
            n++;
        end
        if (!cmd_ready) begin
            tests++;
            fails++;
            $display("FAIL cmd_ready_timeout: got 0, expected 1 within %0d cycles", n);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [NB-1:0] d, input logic [NB-1:0] m,
                        input logic [NC-1:0] tags, input logic [NB-1:0] rd);
        cmd_t rec;
        wait_idle();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_mask  = m;
        step();
        rec.op       = op;
        rec.data     = d;
        rec.mask     = m;
        rec.tags     = tags;
        rec.rdata    = rd;
        rec.lat      = latency(op);
        rec.acc_edge = edge_n;
        acc_q.push_back(rec);
        drv_active = 1;
        drv_acc    = edge_n;
        drv_cap    = rec.lat - 1;
        drv_tags   = tags;
        drv_rd     = rd;
        drive_cam();
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_data  = NB'($urandom);
        cmd_mask  = NB'($urandom);
    endtask

    // Monitor / scoreboard
    initial begin
        cmd_t            cur;
        bit              active;
        bit              cleared;
        int              c;
        logic            e_set, e_srch, e_sel, e_valid;
        logic [2*NB-1:0] e_wl;
        logic [NB-1:0]   exp_cmp, exp_msk;
        active  = 0;
        cleared = 1;
        exp_cmp = '0;
        exp_msk = '0;
        forever begin
            @(negedge CLK);
            if (acc_q.size() > 0) begin
                cur     = acc_q.pop_front();
                active  = 1;
                cleared = 0;
                exp_cmp = cur.data;
                exp_msk = cur.mask;
            end
            e_set = 0; e_srch = 0; e_sel = 0; e_valid = 0; e_wl = '0;
            if (active) begin
                c = edge_n - cur.acc_edge + 1;
                if (c >= cur.lat) begin
                    e_valid = 1;
                end else begin
                    case (cur.op)
                        OpSearch: begin
                            e_set  = (c <= P);
                            e_srch = (c >= 2 * P + 1) && (c <= 3 * P);
                        end
                        OpSelFirst: e_sel = (c <= P);
                        OpWrite:    if (c <= P) e_wl = lines_for(cur.data, cur.mask);
                        default: ;
                    endcase
                end
            end
            check("strobes", {cam_set, cam_perform_search, cam_select_first, cam_write_lines},
                  {e_set, e_srch, e_sel, e_wl});
            check("rsp_valid", rsp_valid, e_valid);
            check("cmd_ready", cmd_ready, !RST && !active);
            check("comparand_mask", {cam_comparand, cam_mask}, {exp_cmp, exp_msk});
            if (e_valid && rsp_valid) begin
                check("rsp_tags", rsp_tags, cur.tags);
                check("rsp_any", rsp_any, cur.tags != '0);
                check("rsp_count", rsp_count, $countones(cur.tags));
                if (cur.op == OpRead) check("rsp_data", rsp_data, cur.rdata);
            end
            if (cleared) check("rsp_reset", {rsp_tags, rsp_data, rsp_any, rsp_count}, '0);
            if (RST) begin
                active  = 0;
                cleared = 1;
                exp_cmp = '0;
                exp_msk = '0;
                acc_q.delete();
            end else if (active && e_valid && rsp_ready) begin
                active = 0;
            end
        end
    end

    // Driver
    initial begin
        RST            = 1'b1;
        cmd_valid      = 1'b0;
        cmd_op         = '0;
        cmd_data       = '0;
        cmd_mask       = '0;
        rsp_ready      = 1'b1;
        cam_tag_wires  = '0;
        cam_read_lines = '0;
        repeat (3) step();
        RST = 1'b0;

        send(OpWrite, 2'b01, 2'b11, NC'($urandom), '0);
        send(OpWrite, 2'b11, 2'b10, NC'($urandom), '0);
        send(OpSearch, 2'b00, 2'b11, 10'b0000000110, '0);
        send(OpSearch, 2'b10, 2'b11, 10'b0000000000, '0);
        send(OpSelFirst, 2'b00, 2'b00, 10'b0000000001, '0);
        send(OpRead, 2'b00, 2'b00, 10'b0100000001, 2'b10);

        // Reset held three cycles while idle.
        wait_idle();
        RST = 1'b1;
        repeat (3) step();
        RST = 1'b0;

        // Back-pressure: response held 20 cycles while commands are offered.
        rsp_ready = 1'b0;
        send(OpSearch, 2'b01, 2'b01, 10'b1010000011, '0);
        repeat (4 * P) step();
        for (int i = 0; i < 20; i++) begin
            cmd_valid = (i % 2 == 0);
            cmd_op    = 2'($urandom);
            step();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        step();

        // Reset during cycle 15 of a SEARCH, then a normal SEARCH.
        send(OpSearch, 2'b11, 2'b11, 10'b1111111111, '0);
        repeat (14) step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        drv_active = 0;
        repeat (50) step();
        send(OpSearch, 2'b00, 2'b01, 10'b0010010010, '0);

        rand_ready = 1;
        for (int k = 0; k < 30; k++) begin
            send(2'($urandom), NB'($urandom), NB'($urandom), NC'($urandom), NB'($urandom));
        end
        rand_ready = 0;
        rsp_ready  = 1'b1;
        wait_idle();
        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not reach the end, %0d failed so far", fails);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cam_sequencer.md
# cam_sequencer

Hardware initiator for the `cam` content-addressable parallel processor. It accepts high-level commands over a valid/ready interface: SEARCH, SELECT_FIRST, WRITE and READ. It expands each command into the timed strobe sequence the CAM's control ports require, then returns captured tags and read data over a valid/ready response channel. It sits between the array controller and `cam`, and replaces bench-driven strobing.

## Interface
- `num_bits`, default 2: CAM word width.
- `num_cells`, default 10: number of CAM cells (tag width).
- `pulse_cycles`, default 10: cycles each strobe (set, perform_search, select_first, write_lines) is held, and the length of each post-strobe gap; ≥1.
- `settle_cycles`, default 100: quiet cycles after a write strobe; ≥1.

Ports:
- `CLK` in 1: clock. Single clock domain, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: high only in IDLE while `RST` is low.
- `cmd_op` in 2: 00 SEARCH, 01 SELECT_FIRST, 10 WRITE, 11 READ.
- `cmd_data` in num_bits: comparand or write value.
- `cmd_mask` in num_bits: search or write mask.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed.
- `rsp_tags` out num_cells: captured `cam_tag_wires`.
- `rsp_data` out num_bits: captured `cam_read_lines`.
- `rsp_any` out 1: OR of `rsp_tags`.
- `rsp_count` out $clog2(num_cells+1): popcount of `rsp_tags`.
- `cam_comparand`, `cam_mask` out num_bits: registered on command accept.
- `cam_set`, `cam_perform_search`, `cam_select_first` out 1: strobes.
- `cam_write_lines` out 2*num_bits: bit 2i = data[i]&mask[i]; bit 2i+1 = ~data[i]&mask[i].
- `cam_tag_wires` in num_cells, `cam_read_lines` in num_bits: CAM outputs.

## Operation
- States: IDLE, SET, SET_GAP, SRCH, SRCH_GAP, SEL, SEL_GAP, WR, WR_SETTLE, RD_WAIT, RESP.
- Accept: `cmd_valid && cmd_ready` at a rising edge. On accept, latch data and mask; drive `cam_comparand` and `cam_mask` from the latch, held until the next accept.
- SEARCH path:
  - SET: `cam_set`=1.
  - SET_GAP: all strobes 0.
  - SRCH: `cam_perform_search`=1.
  - SRCH_GAP: all strobes 0.
  - Capture tags, go to RESP.
- SELECT_FIRST path: SEL (`cam_select_first`=1), then SEL_GAP, capture tags, RESP.
- WRITE path: WR drives the encoded `cam_write_lines`; WR_SETTLE forces `cam_write_lines`=0; capture tags, RESP.
- READ path: RD_WAIT with no strobes for `pulse_cycles`; capture `cam_read_lines` and tags, RESP.
- Phase counter: one down-counter, width $clog2(max(pulse_cycles, settle_cycles)+1). Loaded on each state entry; the state exits when the counter reaches 1.
- Strobes: at most one of `cam_set`, `cam_perform_search`, `cam_select_first`, or nonzero `cam_write_lines` is active in any cycle.
- Response: registered on capture. `rsp_count` and `rsp_any` are computed from the captured tags, never from live inputs.
- RESP: `rsp_*` are held stable until `rsp_valid && rsp_ready`, then the FSM returns to IDLE. `cmd_ready` rises the cycle after that handshake; no command/response overlap.
- Command inputs are ignored outside IDLE.
- Illegal conditions: none; all four opcodes are valid. Mask bits at 0 give a 00 write-line pair, which leaves that bit unchanged.

## Timing
- Reset values:
  - all `cam_*` outputs 0
  - `rsp_valid`=0, `rsp_tags`=0, `rsp_data`=0, `rsp_any`=0, `rsp_count`=0
  - state IDLE
  - `cmd_ready`=0 while `RST` is high, 1 in the first cycle after.
- Reset mid-command: strobes deassert at the next edge; any pending or in-flight response is discarded; no partial strobe resumes.
- Cycle numbering: the accept edge is cycle 0. A strobe of P=`pulse_cycles` is high in cycles 1..P.
- `rsp_valid` first high:
  - SEARCH: cycle 4P+1
  - SELECT_FIRST: cycle 2P+1
  - WRITE: cycle P+`settle_cycles`+1
  - READ: cycle P+1
- Capture samples CAM inputs on the final cycle of the last gap or settle state.
- Back-to-back: minimum spacing is latency+2 cycles, given `rsp_ready` held high.

## Test plan
- Reset: hold `RST` 3 cycles mid-idle. All `cam_*` outputs must be 0 and `rsp_valid`=0. `cmd_ready`=1 on the first cycle after release.
- WRITE, data=2'b01, mask=2'b11: `cam_write_lines`=4'b1001 for exactly 10 cycles, then 0 for 100 cycles; `rsp_valid` rises at cycle 111.
- WRITE, data=2'b11, mask=2'b10: `cam_write_lines`=4'b0100.
- SEARCH, data=0, mask=2'b11, CAM model returns tags 10'b0000000110:
  - `cam_set` high in cycles 1–10, `cam_perform_search` high in cycles 21–30
  - response at cycle 41: `rsp_tags`=0000000110, `rsp_any`=1, `rsp_count`=2.
- No-match SEARCH (tags all 0): `rsp_any`=0, `rsp_count`=0.
- SELECT_FIRST with tags 10'b1111111111 → 10'b0000000001:
  - `cam_select_first` high in cycles 1–10
  - response at cycle 21 with `rsp_count`=1.
- Back-pressure: hold `rsp_ready` low 20 cycles while toggling `cmd_valid`. `rsp_*` stay stable, `cmd_ready`=0, and no command is accepted. After the handshake, `cmd_ready`=1 on the next cycle.
- Reset asserted at cycle 15 of a SEARCH: `cam_perform_search` never rises, `rsp_valid` stays 0, and the next command executes normally.
